// File: rtl/layer_ram_responder_pkg.sv
// Shared types and limits for the layer RAM responder and its storage array.
package layer_ram_responder_pkg;

  localparam int MAX_DEPTH   = 4;
  localparam int MAX_NEURONS = 8;
  localparam int DATA_W      = 16;

  typedef logic [DATA_W-1:0] data;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ACK   = 3'd1,
    RD_FETCH = 3'd2,
    RD_ACK   = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  function automatic int addr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/layer_ram_array.sv
// Single-port storage for all layers: synchronous read, contents never reset.
module layer_ram_array #(
  parameter int DW      = 16,
  parameter int ENTRIES = 32,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [ENTRIES];
  logic [DW-1:0] rdata_r;

  // One access per edge; the read word holds until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/layer_ram_responder.sv
// Request/ack front end for the layer RAM: write, read and whole-array clear.
// Optional per-field bounds checking with err reporting: LAYER_RAM_BOUNDS_CHECK_EN.
module layer_ram_responder
  import layer_ram_responder_pkg::*;
#(
  parameter int DEPTH   = MAX_DEPTH,
  parameter int NEURONS = MAX_NEURONS,
  parameter int DW      = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req,
  input  logic          rw,
  input  logic [31:0]   layer_index,
  input  logic [31:0]   neuron_index,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  output logic          ready,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam int TOTAL = DEPTH * NEURONS;
  localparam int AW    = addr_width(TOTAL);
  localparam logic [AW-1:0] LAST_IDX = AW'(TOTAL - 1);

  state_t        state_r;
  logic          ready_r;
  logic          ack_r;
  logic          err_r;
  logic          rd_oor_r;
  logic [DW-1:0] rdata_r;
  logic [AW-1:0] clr_cnt_r;
  logic [AW-1:0] clr_cnt_inc_s;
  logic [31:0]   addr_full_s;
  logic          in_range_s;
  logic          accept_s;
  logic          mem_we_s;
  logic          mem_re_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;
  logic [DW-1:0] mem_q_s;

  assign addr_full_s   = layer_index * 32'(NEURONS) + neuron_index;
  assign clr_cnt_inc_s = clr_cnt_r + AW'(1);
  assign accept_s      = (state_r == IDLE) && !clr && req;

`ifdef LAYER_RAM_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
  assign in_range_s = (layer_index < 32'(DEPTH)) && (neuron_index < 32'(NEURONS)) &&
                      (addr_full_s < 32'(TOTAL));
`else
  localparam logic BOUNDS_EN = 1'b0;
  // Without field checks only the flat address guards the array.
  assign in_range_s = (addr_full_s < 32'(TOTAL));
`endif

  // Array port steering: the clear sweep owns the port while in CLEAR.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_addr_s  = addr_full_s[AW-1:0];
    mem_wdata_s = wdata;
    if (state_r == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = clr_cnt_r;
      mem_wdata_s = {DW{1'b0}};
    end else if (accept_s) begin
      mem_we_s = rw && in_range_s;
      mem_re_s = !rw;
    end else begin
      mem_we_s = 1'b0;
      mem_re_s = 1'b0;
    end
  end

  // Control FSM: handshakes and the clear sweep, all outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      rd_oor_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      clr_cnt_r <= {AW{1'b0}};
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr) begin
            state_r   <= CLEAR;
            ready_r   <= 1'b0;
            clr_cnt_r <= {AW{1'b0}};
            ack_r     <= (LAST_IDX == {AW{1'b0}});
          end else if (req) begin
            ready_r <= 1'b0;
            if (rw) begin
              state_r <= WR_ACK;
              ack_r   <= 1'b1;
              err_r   <= BOUNDS_EN && !in_range_s;
            end else begin
              state_r  <= RD_FETCH;
              rd_oor_r <= !in_range_s;
            end
          end
        end
        WR_ACK: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
        RD_FETCH: begin
          state_r <= RD_ACK;
          ack_r   <= 1'b1;
          err_r   <= BOUNDS_EN && rd_oor_r;
          rdata_r <= rd_oor_r ? {DW{1'b0}} : mem_q_s;
        end
        RD_ACK: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
        CLEAR: begin
          // ack rides on the cycle that zeroes the final entry.
          if (clr_cnt_r == LAST_IDX) begin
            clr_cnt_r <= {AW{1'b0}};
            state_r   <= IDLE;
            ready_r   <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_inc_s;
            ack_r     <= (clr_cnt_inc_s == LAST_IDX);
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  layer_ram_array #(
    .DW      (DW),
    .ENTRIES (TOTAL),
    .AW      (AW)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_q_s)
  );

  assign ready = ready_r;
  assign ack   = ack_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: doc/layer_ram_responder.md
LAYER_RAM_RESPONDER -- requirements
Module: layer_ram_responder

Interface
- REQ-001 SHALL have parameter DEPTH, default `MAX_DEPTH`; number of layers stored.
- REQ-002 SHALL have parameter NEURONS, default `MAX_NEURONS`; entries per layer.
- REQ-003 SHALL have parameter DW, default 16; width of the shared `data` type.
- REQ-004 SHALL have CLK input, 1 bit; sole clock, all state on posedge.
- REQ-005 SHALL have RST_N input, 1 bit; reset is asynchronous and active-low.
- REQ-006 SHALL have req input, 1 bit; request strobe, sampled only when ready=1.
- REQ-007 SHALL have rw input, 1 bit; 1 = write, 0 = read.
- REQ-008 SHALL have layer_index input, 32 bits; layer address.
- REQ-009 SHALL have neuron_index input, 32 bits; entry address within the layer.
- REQ-010 SHALL have wdata input, DW bits; write data.
- REQ-011 SHALL have clr input, 1 bit; request to zero the whole array.
- REQ-012 SHALL have ready output, 1 bit; high only in IDLE.
- REQ-013 SHALL have ack output, 1 bit; one-cycle completion pulse.
- REQ-014 SHALL have rdata output, DW bits; read result, valid while ack=1.
- REQ-015 SHALL have err output, 1 bit; out-of-range flag, valid while ack=1.

Function
- REQ-016 SHALL implement states IDLE, WR_ACK, RD_FETCH, RD_ACK, CLEAR.
- REQ-017 In IDLE, clr=1 SHALL go to CLEAR, taking priority over a simultaneous req.
- REQ-018 In IDLE, req=1 with rw=1 SHALL commit wdata at the clock edge and go to WR_ACK.
- REQ-019 WR_ACK SHALL assert ack for exactly one cycle, then return to IDLE; write latency is 1 cycle.
- REQ-020 In IDLE, req=1 with rw=0 SHALL latch the address and go to RD_FETCH.
- REQ-021 RD_FETCH SHALL register the array word and go to RD_ACK.
- REQ-022 RD_ACK SHALL drive rdata and ack=1 for one cycle, then return to IDLE; read latency is 2 cycles.
- REQ-023 rdata SHALL hold its last value outside RD_ACK.
- REQ-024 req, clr, rw and the address inputs SHALL be ignored whenever ready=0.
- REQ-025 CLEAR SHALL zero one entry per cycle using a flat counter from 0 to DEPTH*NEURONS-1.
- REQ-026 When the counter reaches its last value, CLEAR SHALL pulse ack, wrap the counter to 0 and return to IDLE.
- REQ-027 The address SHALL be layer_index*NEURONS+neuron_index, computed at full 32-bit width before range checking.

Reset
- REQ-028 RST_N=0 SHALL asynchronously force IDLE, ready=1, ack=0, err=0, rdata=0 and the clear counter to 0.
- REQ-029 Reset asserted mid-CLEAR or mid-read SHALL abort the operation with no ack.
- REQ-030 Array contents SHALL be retained across reset; only clr zeroes them.

Configuration
- REQ-031 With LAYER_RAM_BOUNDS_CHECK_EN defined, layer_index>=DEPTH or neuron_index>=NEURONS SHALL drop the write, return rdata=0 and pulse err together with ack.
- REQ-032 Without LAYER_RAM_BOUNDS_CHECK_EN, err SHALL be tied 0 and out-of-range writes SHALL be dropped.
- REQ-033 Without LAYER_RAM_BOUNDS_CHECK_EN, out-of-range reads SHALL return 0.
- REQ-034 Handshake timing SHALL be identical whether or not LAYER_RAM_BOUNDS_CHECK_EN is defined.

Structure
- REQ-035 The `data` typedef, MAX_DEPTH, MAX_NEURONS and the state enum SHALL live in the shared library package.
- REQ-036 The storage array SHALL be a sub-module, layer_ram_array (single port, synchronous read, no reset on contents).
- REQ-037 The FSM, address computation and bounds check SHALL stay in layer_ram_responder.

Verification
- REQ-038 Write then read: write (layer 1, neuron 2, 0x1234), then read the same address -> ack at req+1; rdata=0x1234 with ack at req+2.
- REQ-039 Busy rejection: pulse req on the cycle after an accepted read -> second request ignored, exactly one ack.
- REQ-040 clr and req asserted together in IDLE -> CLEAR entered; no write occurs; ack after DEPTH*NEURONS cycles; every address then reads 0.
- REQ-041 Bounds (macro on): write layer=DEPTH -> err=1 and ack=1; array unchanged. With the macro off -> err=0 and array unchanged.
- REQ-042 Reset mid-CLEAR at entry 3 -> no ack; entries >=3 keep prior values; ready=1 immediately on reset assertion.
- REQ-043 Corners: write then read (DEPTH-1, NEURONS-1, 0xFFFF) -> rdata=0xFFFF; address (0,0) works likewise.
